bomber_status_encoder: RTL and testbench



---
 rtl/bomber_status_pkg.sv | 28 ++
 rtl/bomber_pos_digit_split.sv | 33 +++
 rtl/bomber_status_encoder.sv | 162 ++++++++++++++++
 tb/tb_bomber_status_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bomber_status_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bomber_status_pkg
//  Description : Shared field layout of the 14-bit per-bomber status word and
//                the encoder state encoding. The overlay decodes with the same
//                offsets, so change them in one place only.
//  Revision    : 1.0 - initial release
// ============================================================================
package bomber_status_pkg;

    localparam int STATUS_W    = 14;
    localparam int UNITS_W     = 4;
    localparam int X_TENS_BIT  = 0;
    localparam int X_UNITS_LSB = 1;
    localparam int Y_TENS_BIT  = 5;
    localparam int Y_UNITS_LSB = 6;
    localparam int LIVES_LSB   = 10;
    localparam int BOMBS_LSB   = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONV_X  = 2'd1,
        ST_CONV_Y  = 2'd2,
        ST_PENDING = 2'd3
    } enc_state_t;

endpackage : bomber_status_pkg
`default_nettype wire

// File: rtl/bomber_pos_digit_split.sv
`default_nettype none
// ============================================================================
//  Module      : bomber_pos_digit_split
//  Description : Combinational saturate-then-split of a binary position into
//                a 1-bit tens digit and a 4-bit units digit (0..9).
//  Revision    : 1.0 - initial release
// ============================================================================
module bomber_pos_digit_split
    import bomber_status_pkg::*;
#(
    parameter int POS_WIDTH = 5,
    parameter int POS_MAX   = 19
) (
    input  logic [POS_WIDTH-1:0] i_pos,
    output logic                 o_tens,
    output logic [UNITS_W-1:0]   o_units
);

    localparam logic [POS_WIDTH-1:0] c_pos_max = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] c_ten     = POS_WIDTH'(10);

    logic [POS_WIDTH-1:0] w_sat;

    // Clamp first, then split. Because the clamped value is at most 19, the
    // units digit can be formed modulo 16 from the low nibble alone.
    always_comb begin
        w_sat   = (i_pos > c_pos_max) ? c_pos_max : i_pos;
        o_tens  = (w_sat >= c_ten);
        o_units = w_sat[UNITS_W-1:0] - (o_tens ? 4'd10 : 4'd0);
    end

endmodule : bomber_pos_digit_split
`default_nettype wire

// File: rtl/bomber_status_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : bomber_status_encoder
//  Description : Accepts one bomber's game state over valid/ready, converts
//                positions to tens/units digits and commits the packed status
//                word only on a vsync rising edge to avoid torn frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module bomber_status_encoder
    import bomber_status_pkg::*;
#(
    parameter int POS_WIDTH = 5,
    parameter int POS_MAX   = 19
) (
    input  logic                 i_pclk,
    input  logic                 i_rst,
    input  logic                 i_vsync,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [POS_WIDTH-1:0] i_pos_x,
    input  logic [POS_WIDTH-1:0] i_pos_y,
    input  logic [1:0]           i_lives,
    input  logic [1:0]           i_bombs,
    output logic [STATUS_W-1:0]  o_status_data,
    output logic                 o_updated
);

    enc_state_t           state_q, state_d;
    logic                 vsync_q, vsync_d;
    logic [POS_WIDTH-1:0] x_q, x_d;
    logic [POS_WIDTH-1:0] y_q, y_d;
    logic [1:0]           lives_q, lives_d;
    logic [1:0]           bombs_q, bombs_d;
    logic                 x_tens_q, x_tens_d;
    logic [UNITS_W-1:0]   x_units_q, x_units_d;
    logic [STATUS_W-1:0]  pending_q, pending_d;
    logic [STATUS_W-1:0]  status_q, status_d;
    logic                 updated_q, updated_d;
    logic                 ready_q, ready_d;

    logic                 w_transfer;
    logic                 w_vsync_rise;
    logic [POS_WIDTH-1:0] w_split_in;
    logic                 w_tens;
    logic [UNITS_W-1:0]   w_units;

    // One splitter shared in time: X during CONV_X, Y during CONV_Y.
    assign w_split_in = (state_q == ST_CONV_Y) ? y_q : x_q;

    bomber_pos_digit_split #(
        .POS_WIDTH (POS_WIDTH),
        .POS_MAX   (POS_MAX)
    ) u_split (
        .i_pos   (w_split_in),
        .o_tens  (w_tens),
        .o_units (w_units)
    );

    assign w_transfer   = i_valid && ready_q;
    assign w_vsync_rise = i_vsync && !vsync_q;

    // Next-state logic: capture, two conversion steps, then hold until vsync.
    always_comb begin
        state_d   = state_q;
        vsync_d   = i_vsync;
        x_d       = x_q;
        y_d       = y_q;
        lives_d   = lives_q;
        bombs_d   = bombs_q;
        x_tens_d  = x_tens_q;
        x_units_d = x_units_q;
        pending_d = pending_q;
        status_d  = status_q;
        updated_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_transfer) begin
                    x_d     = i_pos_x;
                    y_d     = i_pos_y;
                    lives_d = i_lives;
                    bombs_d = i_bombs;
                    state_d = ST_CONV_X;
                end
            end
            ST_CONV_X: begin
                x_tens_d  = w_tens;
                x_units_d = w_units;
                state_d   = ST_CONV_Y;
            end
            ST_CONV_Y: begin
                pending_d                            = '0;
                pending_d[X_TENS_BIT]                = x_tens_q;
                pending_d[X_UNITS_LSB +: UNITS_W]    = x_units_q;
                pending_d[Y_TENS_BIT]                = w_tens;
                pending_d[Y_UNITS_LSB +: UNITS_W]    = w_units;
                pending_d[LIVES_LSB +: 2]            = lives_q;
                pending_d[BOMBS_LSB +: 2]            = bombs_q;
                state_d                              = ST_PENDING;
            end
            ST_PENDING: begin
                // The word already pending is what commits, even if a new
                // state is accepted on the same edge.
                if (w_vsync_rise) begin
                    status_d  = pending_q;
                    updated_d = 1'b1;
                end
                if (w_transfer) begin
                    x_d     = i_pos_x;
                    y_d     = i_pos_y;
                    lives_d = i_lives;
                    bombs_d = i_bombs;
                    state_d = ST_CONV_X;
                end else if (w_vsync_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_PENDING);
    end

    // State and output registers; reset drops any pending or in-flight word.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            vsync_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            lives_q   <= '0;
            bombs_q   <= '0;
            x_tens_q  <= 1'b0;
            x_units_q <= '0;
            pending_q <= '0;
            status_q  <= '0;
            updated_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            vsync_q   <= vsync_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lives_q   <= lives_d;
            bombs_q   <= bombs_d;
            x_tens_q  <= x_tens_d;
            x_units_q <= x_units_d;
            pending_q <= pending_d;
            status_q  <= status_d;
            updated_q <= updated_d;
            ready_q   <= ready_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_status_data = status_q;
    assign o_updated     = updated_q;

endmodule : bomber_status_encoder
`default_nettype wire

// File: tb/tb_bomber_status_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomber_status_encoder
//  Description : Directed self-checking bench for bomber_status_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomber_status_encoder;

    logic        clk;
    logic        rst;
    logic        vsync;
    logic        valid;
    logic        ready;
    logic [4:0]  pos_x;
    logic [4:0]  pos_y;
    logic [1:0]  lives;
    logic [1:0]  bombs;
    logic [13:0] status;
    logic        updated;

    int n_cmp = 0;
    int n_err = 0;

    bomber_status_encoder #(
        .POS_WIDTH (5),
        .POS_MAX   (19)
    ) dut (
        .i_pclk        (clk),
        .i_rst         (rst),
        .i_vsync       (vsync),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_pos_x       (pos_x),
        .i_pos_y       (pos_y),
        .i_lives       (lives),
        .i_bombs       (bombs),
        .o_status_data (status),
        .o_updated     (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a state and hold valid until it is accepted on an edge.
    task automatic send(input logic [4:0] x, input logic [4:0] y,
                        input logic [1:0] l, input logic [1:0] b);
        int k;
        k = 0;
        pos_x = x; pos_y = y; lives = l; bombs = b; valid = 1'b1;
        while (!ready && k < 20) begin
            tick();
            k++;
        end
        if (!ready) begin n_err++; $display("FAIL send_timeout ready got %b want 1", ready); end
        n_cmp++;
        tick();
        valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b1; vsync = 1'b0;
        pos_x = 5'd13; pos_y = 5'd7; lives = 2'd3; bombs = 2'd2;
        for (int i = 0; i < 3; i++) begin
            vsync = ~vsync;
            tick();
            if (status !== 14'h0000) begin n_err++; $display("FAIL reset_status got %h want 0000", status); end
            n_cmp++;
            if (updated !== 1'b0) begin n_err++; $display("FAIL reset_updated got %b want 0", updated); end
            n_cmp++;
            if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
            n_cmp++;
        end
        rst = 1'b0; valid = 1'b0; vsync = 1'b0;
        tick();
        if (status !== 14'h0000) begin n_err++; $display("FAIL post_reset_status got %h want 0000", status); end
        n_cmp++;
    endtask

    task automatic test_basic_commit;
        send(5'd13, 5'd7, 2'd3, 2'd2);
        if (ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_conv got %b want 0", ready); end
        n_cmp++;
        tick(); tick();
        if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_pending got %b want 1", ready); end
        n_cmp++;
        tick();
        if (status !== 14'h0000) begin n_err++; $display("FAIL basic_before_rise got %h want 0000", status); end
        n_cmp++;
        if (updated !== 1'b0) begin n_err++; $display("FAIL basic_upd_before got %b want 0", updated); end
        n_cmp++;
        vsync = 1'b1;
        tick();
        if (status !== 14'h2DC7) begin n_err++; $display("FAIL basic_commit got %h want 2dc7", status); end
        n_cmp++;
        if (updated !== 1'b1) begin n_err++; $display("FAIL basic_upd_pulse got %b want 1", updated); end
        n_cmp++;
        vsync = 1'b0;
        tick();
        if (updated !== 1'b0) begin n_err++; $display("FAIL basic_upd_drop got %b want 0", updated); end
        n_cmp++;
        if (status !== 14'h2DC7) begin n_err++; $display("FAIL basic_hold got %h want 2dc7", status); end
        n_cmp++;
    endtask

    task automatic test_saturation;
        send(5'd25, 5'd31, 2'd0, 2'd0);
        tick(); tick();
        vsync = 1'b1;
        tick();
        if (status !== 14'h0273) begin n_err++; $display("FAIL sat_commit got %h want 0273", status); end
        n_cmp++;
        if (updated !== 1'b1) begin n_err++; $display("FAIL sat_upd got %b want 1", updated); end
        n_cmp++;
        vsync = 1'b0;
        tick();
    endtask

    task automatic test_latest_wins;
        send(5'd13, 5'd7, 2'd3, 2'd2);
        tick(); tick();
        send(5'd4, 5'd0, 2'd1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            if (status !== 14'h0273) begin n_err++; $display("FAIL latest_hold got %h want 0273", status); end
            n_cmp++;
            if (updated !== 1'b0) begin n_err++; $display("FAIL latest_upd got %b want 0", updated); end
            n_cmp++;
            tick();
        end
        vsync = 1'b1;
        tick();
        if (status !== 14'h1408) begin n_err++; $display("FAIL latest_commit got %h want 1408", status); end
        n_cmp++;
        vsync = 1'b0;
        tick();
    endtask

    task automatic test_missed_frame;
        send(5'd25, 5'd31, 2'd0, 2'd0);
        vsync = 1'b1;
        tick();
        if (updated !== 1'b0) begin n_err++; $display("FAIL missed_upd got %b want 0", updated); end
        n_cmp++;
        vsync = 1'b0;
        tick();
        if (status !== 14'h1408) begin n_err++; $display("FAIL missed_hold got %h want 1408", status); end
        n_cmp++;
        vsync = 1'b1;
        tick();
        if (status !== 14'h0273) begin n_err++; $display("FAIL missed_next got %h want 0273", status); end
        n_cmp++;
        if (updated !== 1'b1) begin n_err++; $display("FAIL missed_next_upd got %b want 1", updated); end
        n_cmp++;
        vsync = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous;
        send(5'd13, 5'd7, 2'd3, 2'd2);
        tick(); tick();
        pos_x = 5'd25; pos_y = 5'd31; lives = 2'd0; bombs = 2'd0;
        valid = 1'b1; vsync = 1'b1;
        tick();
        if (status !== 14'h2DC7) begin n_err++; $display("FAIL simul_old got %h want 2dc7", status); end
        n_cmp++;
        if (updated !== 1'b1) begin n_err++; $display("FAIL simul_upd got %b want 1", updated); end
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL simul_ready1 got %b want 0", ready); end
        n_cmp++;
        valid = 1'b0; vsync = 1'b0;
        tick();
        if (ready !== 1'b0) begin n_err++; $display("FAIL simul_ready2 got %b want 0", ready); end
        n_cmp++;
        tick();
        if (ready !== 1'b1) begin n_err++; $display("FAIL simul_ready3 got %b want 1", ready); end
        n_cmp++;
        vsync = 1'b1;
        tick();
        if (status !== 14'h0273) begin n_err++; $display("FAIL simul_new got %h want 0273", status); end
        n_cmp++;
        vsync = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        send(5'd25, 5'd31, 2'd0, 2'd0);
        tick(); tick();
        vsync = 1'b1;
        tick();
        if (status !== 14'h0273) begin n_err++; $display("FAIL repeat_word got %h want 0273", status); end
        n_cmp++;
        if (updated !== 1'b1) begin n_err++; $display("FAIL repeat_upd got %b want 1", updated); end
        n_cmp++;
        vsync = 1'b0;
        tick();
        if (updated !== 1'b0) begin n_err++; $display("FAIL repeat_upd_drop got %b want 0", updated); end
        n_cmp++;
    endtask

    task automatic test_reset_mid;
        send(5'd4, 5'd0, 2'd1, 2'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (status !== 14'h0000) begin n_err++; $display("FAIL rstmid_status got %h want 0000", status); end
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", ready); end
        n_cmp++;
        for (int i = 0; i < 2; i++) begin
            vsync = 1'b1;
            tick();
            if (status !== 14'h0000) begin n_err++; $display("FAIL rstmid_rise got %h want 0000", status); end
            n_cmp++;
            if (updated !== 1'b0) begin n_err++; $display("FAIL rstmid_upd got %b want 0", updated); end
            n_cmp++;
            vsync = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; valid = 1'b0;
        pos_x = '0; pos_y = '0; lives = '0; bombs = '0;
        test_reset();
        test_basic_commit();
        test_saturation();
        test_latest_wins();
        test_missed_frame();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_bomber_status_encoder
`default_nettype wire
